stream_mismatch_checker: RTL and testbench

- Synthesizable on-chip checker that consumes sampled reference and DUT output words and judges them over a fixed-length run.
- Per run it reports sample count, mismatch count, first-mismatch index and bits, and pass/timeout status.
- It is the consuming end of the stimulus/compare harness. A stimulus generator drives `start` and `sample_en`; this block receives and scores the two output streams.

---
 rtl/stream_mismatch_checker.sv | 95 +++++++++
 tb/tb_stream_mismatch_checker.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/stream_mismatch_checker.sv
// Scores sampled reference/DUT word streams over a fixed-length run.
// Reports sample/error counts, first-error details and pass/timeout status.
module stream_mismatch_checker #(
  parameter int WIDTH       = 1,
  parameter int NUM_SAMPLES = 100,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = 1000
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             start,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] ref_val,
  input  logic [WIDTH-1:0] dut_val,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timed_out,
  output logic             mismatch,
  output logic [CNT_W-1:0] clocks,
  output logic [CNT_W-1:0] errors,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [WIDTH-1:0] first_err_bits
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cyc;
  logic [WIDTH-1:0] diff;
  logic             accept, hit, last, tmo, go;

  assign diff   = ref_val ^ dut_val;
  assign hit    = |diff;
  assign accept = (state == S_RUN) && sample_en;
  assign last   = accept && (clocks == CNT_W'(NUM_SAMPLES - 1));
  assign tmo    = (state == S_RUN) && (cyc == CNT_W'(TIMEOUT - 1));
  assign go     = start && (state != S_RUN);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last || tmo) state_nxt = S_DONE;
      S_DONE:  if (start) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) state <= S_IDLE;
    else           state <= state_nxt;
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      cyc            <= '0;
      clocks         <= '0;
      errors         <= '0;
      first_err_idx  <= '0;
      first_err_bits <= '0;
      mismatch       <= 1'b0;
      timed_out      <= 1'b0;
    end else if (go) begin
      cyc            <= '0;
      clocks         <= '0;
      errors         <= '0;
      first_err_idx  <= '0;
      first_err_bits <= '0;
      mismatch       <= 1'b0;
      timed_out      <= 1'b0;
    end else if (state == S_RUN) begin
      cyc <= cyc + CNT_W'(1);
      if (accept) begin
        clocks   <= clocks + CNT_W'(1);
        mismatch <= hit;
        if (hit) begin
          if (errors != '1) errors <= errors + CNT_W'(1);
          // errors==0 before this edge marks the first failing sample
          if (errors == '0) begin
            first_err_idx  <= clocks;
            first_err_bits <= diff;
          end
        end
      end
      // completing on the same edge as the timeout is a normal finish
      if (tmo && !last) timed_out <= 1'b1;
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);
  assign pass = done && (errors == '0) && !timed_out;

endmodule

// File: tb/tb_stream_mismatch_checker.sv
// Table-driven bench for stream_mismatch_checker with a per-sample scoreboard.
module tb_stream_mismatch_checker;
  localparam int WIDTH = 1, NUM_SAMPLES = 100, CNT_W = 16, TIMEOUT = 150;

  logic clk = 1'b0, areset_n = 1'b0, start = 1'b0, sample_en = 1'b0;
  logic [WIDTH-1:0] ref_val = '0, dut_val = '0;
  logic busy, done, pass, timed_out, mismatch;
  logic [CNT_W-1:0] clocks, errors, first_err_idx;
  logic [WIDTH-1:0] first_err_bits;

  stream_mismatch_checker #(.WIDTH(WIDTH), .NUM_SAMPLES(NUM_SAMPLES), .CNT_W(CNT_W),
                            .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .areset_n(areset_n), .start(start), .sample_en(sample_en),
    .ref_val(ref_val), .dut_val(dut_val), .busy(busy), .done(done), .pass(pass),
    .timed_out(timed_out), .mismatch(mismatch), .clocks(clocks), .errors(errors),
    .first_err_idx(first_err_idx), .first_err_bits(first_err_bits));

  always #5 clk = ~clk;

  typedef struct {
    int rst_before;  // mid-run reset sequence before this run
    int period;      // 1: sample every cycle, 2: every other cycle
    int mid_start;   // cycle to pulse start while busy (-1 none)
    int e0, e1, e2;  // sample indices where dut_val is wrong (-1 none)
    int x_cycles, x_clocks, x_errors, x_idx, x_bits, x_to, x_pass;
  } vec_t;

  typedef struct { int clocks; int errors; int mm; } exp_t;

  vec_t vecs[7];
  exp_t sb[$];
  int n_chk = 0, n_fail = 0;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " busy"}, 32'(busy), 0);
    check({tag, " done"}, 32'(done), 0);
    check({tag, " pass"}, 32'(pass), 0);
    check({tag, " timed_out"}, 32'(timed_out), 0);
    check({tag, " mismatch"}, 32'(mismatch), 0);
    check({tag, " clocks"}, 32'(clocks), 0);
    check({tag, " errors"}, 32'(errors), 0);
    check({tag, " first_err_idx"}, 32'(first_err_idx), 0);
    check({tag, " first_err_bits"}, 32'(first_err_bits), 0);
  endtask

  // Start with a mismatching sample on the same cycle: it must not be accepted.
  task automatic pulse_start();
    start = 1'b1; sample_en = 1'b1; ref_val = 1'b1; dut_val = 1'b0;
    step();
    start = 1'b0; sample_en = 1'b0;
    check("start busy", 32'(busy), 1);
    check("start done", 32'(done), 0);
    check("start clocks", 32'(clocks), 0);
    check("start errors", 32'(errors), 0);
    check("start mismatch", 32'(mismatch), 0);
    check("start timed_out", 32'(timed_out), 0);
    check("start first_err_idx", 32'(first_err_idx), 0);
  endtask

  task automatic reset_mid();
    pulse_start();
    for (int j = 0; j < 50; j++) begin
      sample_en = 1'b1; ref_val = 1'b1; dut_val = (j == 3) ? 1'b0 : 1'b1;
      step();
    end
    sample_en = 1'b0;
    check("pre-reset clocks", 32'(clocks), 50);
    check("pre-reset first_err_idx", 32'(first_err_idx), 3);
    #2 areset_n = 1'b0;
    #1 check_zero("async reset");
    #1 areset_n = 1'b1;
    step();
    check("post-reset busy", 32'(busy), 0);
    check("post-reset done", 32'(done), 0);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int k = 0, nerr = 0, n = 0;
    exp_t e, got;
    if (v.rst_before != 0) reset_mid();
    pulse_start();
    while (done !== 1'b1) begin
      if (n >= 400) begin
        n_chk++; n_fail++;
        $display("FAIL vec%0d done timeout: no done after %0d cycles", id, n);
        break;
      end
      sample_en = (v.period == 1) || (n % 2 == 0);
      start = (n == v.mid_start);
      ref_val = 1'b1;
      dut_val = (k == v.e0 || k == v.e1 || k == v.e2) ? 1'b0 : 1'b1;
      if (sample_en) begin
        e.mm = (dut_val != ref_val);
        nerr += e.mm;
        k++;
        e.clocks = k; e.errors = nerr;
        sb.push_back(e);
      end
      step();
      start = 1'b0;
      n++;
      if (sb.size() > 0) begin
        got = sb.pop_front();
        if (clocks !== CNT_W'(got.clocks) || errors !== CNT_W'(got.errors)
            || mismatch !== got.mm[0]) begin
          check($sformatf("vec%0d sample%0d clocks", id, got.clocks - 1), 32'(clocks), got.clocks);
          check($sformatf("vec%0d sample%0d errors", id, got.clocks - 1), 32'(errors), got.errors);
          check($sformatf("vec%0d sample%0d mismatch", id, got.clocks - 1), 32'(mismatch), got.mm);
        end else n_chk++;
      end
    end
    sample_en = 1'b0;
    check($sformatf("vec%0d run cycles", id), n, v.x_cycles);
    check($sformatf("vec%0d busy", id), 32'(busy), 0);
    check($sformatf("vec%0d pass", id), 32'(pass), v.x_pass);
    check($sformatf("vec%0d timed_out", id), 32'(timed_out), v.x_to);
    check($sformatf("vec%0d clocks", id), 32'(clocks), v.x_clocks);
    check($sformatf("vec%0d errors", id), 32'(errors), v.x_errors);
    check($sformatf("vec%0d first_err_idx", id), 32'(first_err_idx), v.x_idx);
    check($sformatf("vec%0d first_err_bits", id), 32'(first_err_bits), v.x_bits);
    // DONE must ignore samples and hold every result
    sample_en = 1'b1; ref_val = 1'b1; dut_val = 1'b0;
    repeat (3) step();
    sample_en = 1'b0;
    check($sformatf("vec%0d hold done", id), 32'(done), 1);
    check($sformatf("vec%0d hold clocks", id), 32'(clocks), v.x_clocks);
    check($sformatf("vec%0d hold errors", id), 32'(errors), v.x_errors);
    check($sformatf("vec%0d hold pass", id), 32'(pass), v.x_pass);
  endtask

  initial begin
    //         rst per mid  e0  e1  e2  cyc clk err idx bit to pass
    vecs[0] = '{0, 1, 50, -1, -1, -1, 100, 100, 0, 0, 0, 0, 1};
    vecs[1] = '{0, 1, -1,  7, 42, -1, 100, 100, 2, 7, 1, 0, 0};
    vecs[2] = '{0, 2, -1, -1, -1, -1, 150,  75, 0, 0, 0, 1, 0};
    vecs[3] = '{1, 1, -1, -1, -1, -1, 100, 100, 0, 0, 0, 0, 1};
    vecs[4] = '{0, 1, -1,  0,  1, 99, 100, 100, 3, 0, 1, 0, 0};
    vecs[5] = '{0, 1, -1, -1, -1, -1, 100, 100, 0, 0, 0, 0, 1};
    vecs[6] = '{0, 1, -1, 99, -1, -1, 100, 100, 1, 99, 1, 0, 0};

    #12 check_zero("reset");
    #3 areset_n = 1'b1;
    step();
    // samples in IDLE are ignored
    for (int j = 0; j < 10; j++) begin
      sample_en = 1'b1; ref_val = 1'b1; dut_val = 1'b0;
      step();
    end
    sample_en = 1'b0;
    check_zero("idle samples");

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
